reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//  8x16 general-purpose register file with two combinational read ports and one write port.
//  Read port 1 drives the Shift unit's Reg_read_data_1 operand; port 2 drives the ALU's second operand.
//  Holds a pending-write scoreboard that stalls issue while a source or destination register awaits writeback.
// PARAMETERS
//  N       16  data width (bits)
//  ADDR_W  3   register address width
//  NREGS   8   register count (= 2**ADDR_W); R0 reads as zero
// PORTS
//  clk              in   1       rising-edge clock
//  rst_n            in   1       async active-low reset
//  Reg_read_addr_1  in   ADDR_W  source 1 address
//  Reg_read_addr_2  in   ADDR_W  source 2 address
//  Reg_read_data_1  out  N       source 1 data (to Shift unit)
//  Reg_read_data_2  out  N       source 2 data
//  Reg_write_en     in   1       writeback strobe
//  Reg_write_addr   in   ADDR_W  writeback destination
//  Reg_write_data   in   N       writeback data
//  Issue_valid      in   1       decode presents an instruction using addr_1/addr_2 and Issue_dest
//  Issue_dest       in   ADDR_W  destination of the issuing instruction
//  Stall            out  1       issue must hold; instruction not accepted this cycle
//  Pending          out  NREGS   scoreboard bits (debug/visibility)
// BEHAVIOUR
//  - Reset (async assert, sync-released by top): all regs = 0, Pending = 0.
//    Stall = 0 while in reset. Read data = 0.
//  - Reads: combinational, zero latency. Address 0 always returns 0.
//  - Write: on posedge clk when Reg_write_en && Reg_write_addr != 0. Writes to R0 are discarded.
//  - Scoreboard, per register r != 0:
//      set   on posedge when Issue_valid && !Stall && Issue_dest == r
//      clear on posedge when Reg_write_en && Reg_write_addr == r
//      set and clear on the same r in the same cycle -> set wins (new producer supersedes)
//    Issue_dest = 0 never sets a bit.
//  - Stall = Issue_valid && (P[addr_1] || P[addr_2] || P[Issue_dest]), with P[0] = 0.
//    Combinational, same cycle.
//  - No issue handshake beyond Stall: decode holds all Issue_* and read addrs stable while Stall = 1.
//  - Reset asserted mid-operation: regs and Pending clear immediately.
//    An in-flight writeback that arrives after reset is still written (no tagging).
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined:
//    - Read address == Reg_write_addr (!= 0) with Reg_write_en -> read returns Reg_write_data in the same cycle.
//    - P[x] being cleared this cycle counts as 0 in the Stall equation.
//  REG_FILE_BYPASS_EN undefined:
//    - Reads return the stored value; new data is visible the cycle after the write.
//    - Stall uses registered Pending only, so a dependent instruction stalls one extra cycle.
// STRUCTURE
//  - Shared package cpu_pkg: N, ADDR_W, NREGS, REG_ZERO = 3'd0, and a reg_addr_t typedef.
//    The Shift unit and ALU import the same N.
//  - Sub-module reg_scoreboard: Pending vector, set/clear priority, Stall equation.
//  - reg_file instantiates reg_scoreboard alongside the storage array and read muxes.
// TESTING
//  1. Reset: rst_n = 0 mid-run -> all reads 0, Pending = 8'h00, Stall = 0, all immediately on reset assertion.
//  2. Write R3 = 16'h0010, then read addr_1 = 3 -> Reg_read_data_1 = 16'h0010 next cycle.
//     Write R0 = 16'hFFFF -> R0 still reads 0.
//  3. Issue dest = 5, then issue with addr_1 = 5 -> Stall = 1 and Pending[5] = 1.
//     Write R5 = 16'h1234 -> Pending[5] clears; Stall drops next cycle (same cycle with BYPASS_EN).
//  4. Same cycle: write R2 and accepted issue dest = 2 -> Pending[2] = 1 afterwards (set wins).
//  5. BYPASS_EN: write R4 = 16'hABCD with addr_2 = 4 in the same cycle -> Reg_read_data_2 = 16'hABCD that cycle.
//     Without BYPASS_EN -> old value that cycle.
//  6. WAW: Pending[6] = 1, issue dest = 6 with sources R1/R2 free -> Stall = 1 until R6 is written back.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU datapath definitions. The register file, Shift unit and ALU all
// import this package, so they agree on the data width and register addressing.
//   N        : data width in bits
//   ADDR_W   : register address width
//   NREGS    : register count (2**ADDR_W); R0 is hard-wired to zero
//   REG_ZERO : address of the zero register
//   reg_addr_t / reg_data_t : address and data types
//   reg_onehot() : address-to-one-hot decode with R0 always masked out
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int N      = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [N-1:0]      reg_data_t;

    localparam reg_addr_t REG_ZERO = 3'd0;

    // One-hot decode of a register address, qualified by en. The R0 bit is
    // always 0 because R0 can never be written or become pending.
    function automatic logic [NREGS-1:0] reg_onehot(input reg_addr_t addr, input logic en);
        logic [NREGS-1:0] vec;
        vec = {NREGS{1'b0}};
        if (en && (addr != REG_ZERO)) begin
            vec[addr] = 1'b1;
        end else begin
            vec = {NREGS{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// -----------------------------------------------------------------------------
// reg_file_if
// Bundles the register-file read, writeback and issue/scoreboard signals.
//   master : decode/writeback side (drives addresses, write strobe, issue)
//   slave  : register file side (returns read data, Stall, Pending)
// -----------------------------------------------------------------------------
interface reg_file_if;
    import cpu_pkg::*;

    reg_addr_t          Reg_read_addr_1;
    reg_addr_t          Reg_read_addr_2;
    reg_data_t          Reg_read_data_1;
    reg_data_t          Reg_read_data_2;
    logic               Reg_write_en;
    reg_addr_t          Reg_write_addr;
    reg_data_t          Reg_write_data;
    logic               Issue_valid;
    reg_addr_t          Issue_dest;
    logic               Stall;
    logic [NREGS-1:0]   Pending;

    modport master (
        output Reg_read_addr_1, Reg_read_addr_2,
        output Reg_write_en, Reg_write_addr, Reg_write_data,
        output Issue_valid, Issue_dest,
        input  Reg_read_data_1, Reg_read_data_2, Stall, Pending
    );

    modport slave (
        input  Reg_read_addr_1, Reg_read_addr_2,
        input  Reg_write_en, Reg_write_addr, Reg_write_data,
        input  Issue_valid, Issue_dest,
        output Reg_read_data_1, Reg_read_data_2, Stall, Pending
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Pending-write scoreboard: one bit per register marking an issued producer
// whose writeback has not arrived yet. Generates the issue Stall.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   issue_valid_i       : decode presents an instruction
//   issue_dest_i        : its destination register
//   rd_addr_1_i/2_i     : its source registers
//   wr_en_i, wr_addr_i  : writeback strobe and destination
//   stall_o             : instruction must hold this cycle (combinational)
//   pending_o           : scoreboard vector
// Optional feature macro: REG_FILE_BYPASS_EN -- a bit being cleared by this
// cycle's writeback no longer counts towards Stall.
// -----------------------------------------------------------------------------
module reg_scoreboard
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid_i,
    input  reg_addr_t         issue_dest_i,
    input  reg_addr_t         rd_addr_1_i,
    input  reg_addr_t         rd_addr_2_i,
    input  logic              wr_en_i,
    input  reg_addr_t         wr_addr_i,
    output logic              stall_o,
    output logic [NREGS-1:0]  pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] set_vec_s;
    logic [NREGS-1:0] clr_vec_s;
    logic [NREGS-1:0] eff_pend_s;
    logic             stall_s;

    // Stall equation and next-state pending vector (set beats clear).
    always_comb begin
        clr_vec_s = reg_onehot(wr_addr_i, wr_en_i);
`ifdef REG_FILE_BYPASS_EN
        eff_pend_s = pending_q & ~clr_vec_s;
`else
        eff_pend_s = pending_q;
`endif
        // R0 never becomes pending, so eff_pend_s[0] is always 0.
        if (rst_n && issue_valid_i) begin
            stall_s = eff_pend_s[rd_addr_1_i] | eff_pend_s[rd_addr_2_i] | eff_pend_s[issue_dest_i];
        end else begin
            stall_s = 1'b0;
        end
        set_vec_s = reg_onehot(issue_dest_i, issue_valid_i && !stall_s);
        pending_d = (pending_q & ~clr_vec_s) | set_vec_s;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= {NREGS{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign stall_o   = stall_s;
    assign pending_o = pending_q;

endmodule

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// 8 x 16-bit register file: two combinational read ports, one write port,
// plus a pending-write scoreboard that stalls issue on RAW/WAW hazards.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : async active-low reset (clears storage and scoreboard)
//   bus    : reg_file_if.slave -- read addr/data, writeback, issue, Stall, Pending
// R0 always reads 0 and ignores writes.
// Optional feature macro: REG_FILE_BYPASS_EN -- a read of the register being
// written this cycle returns the write data in the same cycle.
// -----------------------------------------------------------------------------
module reg_file
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);

    reg_data_t regs_q [NREGS];
    reg_data_t regs_d [NREGS];
    logic      wr_hit_s;
    logic      stall_s;
    logic [NREGS-1:0] pending_s;

    // Read-port mux: zero register, optional write bypass, then storage.
    function automatic reg_data_t read_port(input reg_addr_t addr);
        reg_data_t data;
        if (!rst_n || (addr == REG_ZERO)) begin
            data = {N{1'b0}};
`ifdef REG_FILE_BYPASS_EN
        end else if (wr_hit_s && (bus.Reg_write_addr == addr)) begin
            data = bus.Reg_write_data;
`endif
        end else begin
            data = regs_q[addr];
        end
        return data;
    endfunction

    // Write decode and next-state storage.
    always_comb begin
        wr_hit_s = bus.Reg_write_en && (bus.Reg_write_addr != REG_ZERO);
        regs_d   = regs_q;
        if (wr_hit_s) begin
            regs_d[bus.Reg_write_addr] = bus.Reg_write_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {N{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (bus.Issue_valid),
        .issue_dest_i  (bus.Issue_dest),
        .rd_addr_1_i   (bus.Reg_read_addr_1),
        .rd_addr_2_i   (bus.Reg_read_addr_2),
        .wr_en_i       (bus.Reg_write_en),
        .wr_addr_i     (bus.Reg_write_addr),
        .stall_o       (stall_s),
        .pending_o     (pending_s)
    );

    assign bus.Reg_read_data_1 = read_port(bus.Reg_read_addr_1);
    assign bus.Reg_read_data_2 = read_port(bus.Reg_read_addr_2);
    assign bus.Stall           = stall_s;
    assign bus.Pending         = pending_s;

endmodule
